// File: rtl/alien_hit_scan.sv
// Per-frame bullet-vs-alien overlap scanner: walks the grid one alien per cycle, owns the alive bitmap, emits a score event.
// Optional `ALIEN_RESPAWN_EN: a frame arriving with every alien dead reloads the wave and adds the wave_o counter.
module alien_hit_scan #(
  parameter int rows_p    = 5,
  parameter int cols_p    = 11,
  parameter int alien_w_p = 16,
  parameter int alien_h_p = 16,
  parameter int gap_x_p   = 8,
  parameter int gap_y_p   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       frame_i,
  input  logic [9:0]                 grid_left_i,
  input  logic [9:0]                 grid_top_i,
  input  logic                       bullet_active_i,
  input  logic [9:0]                 bullet_left_i,
  input  logic [9:0]                 bullet_right_i,
  input  logic [9:0]                 bullet_top_i,
  input  logic [9:0]                 bullet_bot_i,
  output logic                       enemy_was_hit_o,
  output logic [6:0]                 hit_index_o,
  output logic [rows_p*cols_p-1:0]   alive_o,
  output logic [6:0]                 alive_count_o,
  output logic                       all_dead_o,
  output logic                       busy_o,
  output logic [7:0]                 points_o,
  output logic                       valid_o,
  input  logic                       ready_i
`ifdef ALIEN_RESPAWN_EN
  ,
  output logic [3:0]                 wave_o
`endif
);

  localparam int          n_lp          = rows_p * cols_p;
  localparam logic [10:0] pitch_x_lp    = 11'(alien_w_p + gap_x_p);
  localparam logic [10:0] pitch_y_lp    = 11'(alien_h_p + gap_y_p);
  localparam logic [10:0] w_m1_lp       = 11'(alien_w_p - 1);
  localparam logic [10:0] h_m1_lp       = 11'(alien_h_p - 1);
  localparam logic [6:0]  count_full_lp = 7'(n_lp);
  localparam logic [6:0]  last_idx_lp   = 7'(n_lp - 1);
  localparam logic [6:0]  last_col_lp   = 7'(cols_p - 1);
  localparam logic [7:0]  top_pts_lp    = 8'(10 * rows_p);
  localparam logic [7:0]  row_pts_lp    = 8'd10;

  typedef enum logic [1:0] {
    st_idle,
    st_scan,
    st_report
  } state_e;

  state_e            state_q;
  logic [10:0]       bl_q, br_q, bt_q, bb_q;
  logic [10:0]       grid_left_q;
  logic [10:0]       ax_q, ay_q;
  logic [6:0]        col_q;
  logic [6:0]        idx_q;
  logic [7:0]        row_pts_q;
  logic [n_lp-1:0]   sel_q;
  logic              hit_q;

  // Current alien box, derived from the running origin rather than row/col products.
  logic [10:0] a_right, a_bot;
  logic        overlap, cur_alive, hit_now;

  assign a_right   = ax_q + w_m1_lp;
  assign a_bot     = ay_q + h_m1_lp;
  assign overlap   = (bl_q <= a_right) && (br_q >= ax_q) &&
                     (bt_q <= a_bot)   && (bb_q >= ay_q);
  assign cur_alive = |(alive_o & sel_q);
  assign hit_now   = cur_alive && overlap;

  always_ff @(posedge clk_i) begin
    // NOTE: the alive bitmap is ordinary flops, so it is reset along with the rest; a RAM here would need an explicit clear sweep instead.
    if (!reset_i) begin
      state_q         <= st_idle;
      alive_o         <= '1;
      alive_count_o   <= count_full_lp;
      enemy_was_hit_o <= 1'b0;
      hit_index_o     <= '0;
      points_o        <= '0;
      valid_o         <= 1'b0;
      busy_o          <= 1'b0;
      all_dead_o      <= 1'b0;
      bl_q            <= '0;
      br_q            <= '0;
      bt_q            <= '0;
      bb_q            <= '0;
      grid_left_q     <= '0;
      ax_q            <= '0;
      ay_q            <= '0;
      col_q           <= '0;
      idx_q           <= '0;
      row_pts_q       <= '0;
      sel_q           <= '0;
      hit_q           <= 1'b0;
`ifdef ALIEN_RESPAWN_EN
      wave_o          <= '0;
`endif
    end else begin
      enemy_was_hit_o <= 1'b0;
      hit_q           <= 1'b0;
      // Tracks the registered count, so it trails the final kill by one cycle.
      all_dead_o      <= (alive_count_o == 7'd0);

      case (state_q)
        st_idle: begin
          if (frame_i && bullet_active_i && !all_dead_o) begin
            bl_q        <= {1'b0, bullet_left_i};
            br_q        <= {1'b0, bullet_right_i};
            bt_q        <= {1'b0, bullet_top_i};
            bb_q        <= {1'b0, bullet_bot_i};
            grid_left_q <= {1'b0, grid_left_i};
            ax_q        <= {1'b0, grid_left_i};
            ay_q        <= {1'b0, grid_top_i};
            col_q       <= '0;
            idx_q       <= '0;
            row_pts_q   <= top_pts_lp;
            sel_q       <= {{(n_lp-1){1'b0}}, 1'b1};
            busy_o      <= 1'b1;
            state_q     <= st_scan;
          end
`ifdef ALIEN_RESPAWN_EN
          else if (frame_i && all_dead_o) begin
            alive_o       <= '1;
            alive_count_o <= count_full_lp;
            if (wave_o != 4'd15) wave_o <= wave_o + 4'd1;
          end
`endif
        end

        st_scan: begin
          if (hit_now) begin
            alive_o       <= alive_o & ~sel_q;
            alive_count_o <= alive_count_o - 7'd1;
            hit_index_o   <= idx_q;
            points_o      <= row_pts_q;
            hit_q         <= 1'b1;
            state_q       <= st_report;
          end else if (idx_q == last_idx_lp) begin
            busy_o  <= 1'b0;
            state_q <= st_idle;
          end else begin
            idx_q <= idx_q + 7'd1;
            sel_q <= sel_q << 1;
            if (col_q == last_col_lp) begin
              col_q     <= '0;
              ax_q      <= grid_left_q;
              ay_q      <= ay_q + pitch_y_lp;
              row_pts_q <= row_pts_q - row_pts_lp;
            end else begin
              col_q <= col_q + 7'd1;
              ax_q  <= ax_q + pitch_x_lp;
            end
          end
        end

        st_report: begin
          // The pulse and the score event go out one cycle after the bitmap update.
          if (hit_q) begin
            enemy_was_hit_o <= 1'b1;
            valid_o         <= 1'b1;
          end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            state_q <= st_idle;
          end
        end

        default: begin
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
          state_q <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alien_hit_scan.sv
// Self-checking bench for alien_hit_scan: directed cases plus randomized frames against a geometric reference model.
module tb_alien_hit_scan;

  localparam int ROWS = 5;
  localparam int COLS = 11;
  localparam int N    = ROWS * COLS;
  localparam int AW   = 16;
  localparam int AH   = 16;
  localparam int PX   = 24;
  localparam int PY   = 24;
  localparam int WIN  = 80;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        frame_i = 1'b0;
  logic [9:0]  grid_left_i = '0;
  logic [9:0]  grid_top_i = '0;
  logic        bullet_active_i = 1'b0;
  logic [9:0]  bullet_left_i = '0;
  logic [9:0]  bullet_right_i = '0;
  logic [9:0]  bullet_top_i = '0;
  logic [9:0]  bullet_bot_i = '0;
  logic        ready_i = 1'b1;
  logic        enemy_was_hit_o;
  logic [6:0]  hit_index_o;
  logic [N-1:0] alive_o;
  logic [6:0]  alive_count_o;
  logic        all_dead_o;
  logic        busy_o;
  logic [7:0]  points_o;
  logic        valid_o;
`ifdef ALIEN_RESPAWN_EN
  logic [3:0]  wave_o;
`endif

  alien_hit_scan dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .frame_i         (frame_i),
    .grid_left_i     (grid_left_i),
    .grid_top_i      (grid_top_i),
    .bullet_active_i (bullet_active_i),
    .bullet_left_i   (bullet_left_i),
    .bullet_right_i  (bullet_right_i),
    .bullet_top_i    (bullet_top_i),
    .bullet_bot_i    (bullet_bot_i),
    .enemy_was_hit_o (enemy_was_hit_o),
    .hit_index_o     (hit_index_o),
    .alive_o         (alive_o),
    .alive_count_o   (alive_count_o),
    .all_dead_o      (all_dead_o),
    .busy_o          (busy_o),
    .points_o        (points_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i)
`ifdef ALIEN_RESPAWN_EN
    ,
    .wave_o          (wave_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: which aliens live, how many, which wave.
  bit m_alive [N];
  int m_count;
  int m_wave;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_alive[k] = 1'b1;
    m_count = N;
    m_wave  = 0;
  endfunction

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k] = m_alive[k];
    return v;
  endfunction

  // Lowest live alien whose box overlaps the bullet, or -1.
  function automatic int find_hit(input int gl, input int gt, input int bl, input int br,
                                  input int bt, input int bb);
    for (int k = 0; k < N; k++) begin
      int left, top;
      left = gl + (k % COLS) * PX;
      top  = gt + (k / COLS) * PY;
      if (m_alive[k] && bl <= left + AW - 1 && br >= left && bt <= top + AH - 1 && bb >= top)
        return k;
    end
    return -1;
  endfunction

  function automatic int clamp10(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "/pulse"}, 64'(enemy_was_hit_o), 64'd0);
    check({tag, "/index"}, 64'(hit_index_o), 64'd0);
    check({tag, "/points"}, 64'(points_o), 64'd0);
    check({tag, "/valid"}, 64'(valid_o), 64'd0);
    check({tag, "/busy"}, 64'(busy_o), 64'd0);
    check({tag, "/all_dead"}, 64'(all_dead_o), 64'd0);
    check({tag, "/alive"}, 64'(alive_o), {{(64-N){1'b0}}, {N{1'b1}}});
    check({tag, "/count"}, 64'(alive_count_o), 64'(N));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_i = 1'b0;
    frame_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check_reset_state(tag);
    reset_i = 1'b1;
    model_reset();
  endtask

  // One frame: pulse frame_i, scramble the live inputs while the scan runs, and
  // compare pulse timing, busy length, handshake and final bitmap to the model.
  task automatic run_frame(input string tag, input int gl, input int gt, input logic act,
                           input int bl, input int br, input int bt, input int bb, input int hold);
    int  k, pulse_c, pulses, first_pulse, busy_n, exp_busy, exp_pts;
    bit  scans;
    scans = act && (m_count > 0);
    k = scans ? find_hit(gl, gt, bl, br, bt, bb) : -1;
    pulse_c = k + 2;
    exp_pts = (k >= 0) ? 10 * (ROWS - k / COLS) : 0;
    exp_busy = !scans ? 0 : ((k < 0) ? N : k + 3 + hold);

    @(negedge clk);
    grid_left_i     = 10'(gl);
    grid_top_i      = 10'(gt);
    bullet_active_i = act;
    bullet_left_i   = 10'(bl);
    bullet_right_i  = 10'(br);
    bullet_top_i    = 10'(bt);
    bullet_bot_i    = 10'(bb);
    ready_i         = (hold == 0);
    frame_i         = 1'b1;
    @(posedge clk);

    pulses = 0;
    first_pulse = -1;
    busy_n = 0;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      frame_i = 1'b0;
      if (enemy_was_hit_o) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c;
      end
      if (busy_o) busy_n++;
      if (k >= 0 && c >= pulse_c && c <= pulse_c + hold) begin
        check({tag, "/valid_held"}, 64'(valid_o), 64'd1);
        check({tag, "/points_held"}, 64'(points_o), 64'(exp_pts));
        check({tag, "/index_held"}, 64'(hit_index_o), 64'(k));
      end
      if (k >= 0 && c == pulse_c + hold + 1) begin
        check({tag, "/valid_dropped"}, 64'(valid_o), 64'd0);
        check({tag, "/idle_after_accept"}, 64'(busy_o), 64'd0);
      end
      grid_left_i     = 10'($urandom);
      grid_top_i      = 10'($urandom);
      bullet_left_i   = 10'($urandom);
      bullet_right_i  = 10'($urandom);
      bullet_top_i    = 10'($urandom);
      bullet_bot_i    = 10'($urandom);
      bullet_active_i = 1'($urandom);
      ready_i = (k >= 0) ? (c >= pulse_c + hold) : 1'b1;
      if (k >= 0 && hold >= 5 && c == pulse_c + 3) begin
        frame_i = 1'b1;
        bullet_active_i = 1'b1;
      end
    end

    if (k >= 0) begin
      m_alive[k] = 1'b0;
      m_count--;
    end
`ifdef ALIEN_RESPAWN_EN
    else if (m_count == 0) begin
      for (int j = 0; j < N; j++) m_alive[j] = 1'b1;
      m_count = N;
      if (m_wave < 15) m_wave++;
    end
`endif

    check({tag, "/pulses"}, 64'(pulses), 64'((k >= 0) ? 1 : 0));
    if (k >= 0) check({tag, "/pulse_cycle"}, 64'(first_pulse), 64'(pulse_c));
    check({tag, "/busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    check({tag, "/alive"}, 64'(alive_o), model_vec());
    check({tag, "/count"}, 64'(alive_count_o), 64'(m_count));
    check({tag, "/all_dead"}, 64'(all_dead_o), 64'(m_count == 0));
`ifdef ALIEN_RESPAWN_EN
    check({tag, "/wave"}, 64'(wave_o), 64'(m_wave));
`endif
  endtask

  initial begin
    model_reset();
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    do_reset("reset");

    run_frame("hit0", 100, 50, 1'b1, 105, 106, 60, 63, 0);
    run_frame("hit1_edge", 100, 50, 1'b1, 124, 124, 60, 63, 0);
    run_frame("hit2_hold", 100, 50, 1'b1, 148, 149, 60, 63, 10);

    do_reset("reset2");
    run_frame("span_alive0", 100, 50, 1'b1, 115, 124, 60, 63, 0);
    run_frame("span_dead0", 100, 50, 1'b1, 115, 124, 60, 63, 0);
    run_frame("repeat_dead0", 100, 50, 1'b1, 105, 106, 60, 63, 0);
    run_frame("gap", 100, 50, 1'b1, 116, 123, 60, 63, 0);
    run_frame("inactive", 100, 50, 1'b0, 140, 150, 60, 63, 0);
    run_frame("last_alien", 100, 50, 1'b1, 100 + 10 * PX + 15, 400, 50 + 4 * PY + 15, 500, 0);

    for (int i = 0; i < 25; i++) begin
      int gl, gt, bl, bt;
      gl = int'($urandom_range(0, 1023));
      gt = int'($urandom_range(0, 1023));
      bl = clamp10(gl + int'($urandom_range(0, 270)) - 5);
      bt = clamp10(gt + int'($urandom_range(0, 125)) - 5);
      run_frame($sformatf("rand%0d", i), gl, gt, ($urandom_range(0, 7) != 0),
                bl, clamp10(bl + int'($urandom_range(0, 10))),
                bt, clamp10(bt + int'($urandom_range(0, 10))),
                int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a scan aimed at alien 40.
    @(negedge clk);
    grid_left_i = 10'd100;
    grid_top_i = 10'd50;
    bullet_active_i = 1'b1;
    bullet_left_i = 10'd270;
    bullet_right_i = 10'd271;
    bullet_top_i = 10'd125;
    bullet_bot_i = 10'd126;
    ready_i = 1'b1;
    frame_i = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      frame_i = 1'b0;
      if (c == 10) check("midscan/busy", 64'(busy_o), 64'd1);
    end
    reset_i = 1'b0;
    @(negedge clk);
    check_reset_state("midscan_reset");
    reset_i = 1'b1;
    model_reset();
    begin
      int stray;
      stray = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (enemy_was_hit_o || busy_o || valid_o) stray++;
      end
      check("midscan/no_stray", 64'(stray), 64'd0);
    end

    for (int k = 0; k < N; k++) begin
      int bl, bt;
      bl = 100 + (k % COLS) * PX + 5;
      bt = 50 + (k / COLS) * PY + 5;
      run_frame($sformatf("kill%0d", k), 100, 50, 1'b1, bl, bl + 6, bt, bt + 6, 0);
    end
    run_frame("dead_frame", 100, 50, 1'b1, 105, 106, 60, 63, 0);
    run_frame("after_dead", 100, 50, 1'b1, 105, 106, 60, 63, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
